// File: rtl/timer_pkg.sv
// Shared types and default widths for the multi-channel timer.
package timer_pkg;

  localparam int unsigned DEF_N  = 10;
  localparam int unsigned DEF_CH = 4;
  localparam int unsigned DEF_PW = 8;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle of the timer array; master drives controls, slave reports state.
interface multi_timer_if
  import timer_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CH = DEF_CH,
  parameter int unsigned PW = DEF_PW
);

  logic [PW-1:0]   presc_div;
  logic [CH-1:0]   start;
  logic [CH-1:0]   stop;
  logic [CH-1:0]   pause;
  logic [CH-1:0]   mode;
  logic [CH*N-1:0] load_val;
  logic [CH*N-1:0] end_val;
  logic [CH-1:0]   irq_en;
  logic [CH-1:0]   irq_clr;
  logic [CH*N-1:0] count;
  logic [CH-1:0]   running;
  logic [CH-1:0]   done;
  logic [CH-1:0]   expired;
  logic [CH-1:0]   irq_status;
  logic            irq;

  modport master (
    output presc_div, start, stop, pause, mode, load_val, end_val, irq_en, irq_clr,
    input  count, running, done, expired, irq_status, irq
  );

  modport slave (
    input  presc_div, start, stop, pause, mode, load_val, end_val, irq_en, irq_clr,
    output count, running, done, expired, irq_status, irq
  );

endinterface

// File: rtl/timer_channel.sv
// One down-counting channel: start > stop > tick; expiry flags are registered, so
// they appear one cycle after the terminal tick. No backpressure.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic         irq_clr,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] end_val,
  output logic [N-1:0] count,
  output logic         running,
  output logic         done,
  output logic         expired,
  output logic         irq_status
);

  ch_state_e    state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         exp_q, exp_d;
  logic         sts_q, sts_d;
  logic         mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
      sts_q   <= 1'b0;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
      sts_q   <= sts_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    exp_d   = 1'b0;
    sts_d   = sts_q & ~irq_clr;
    mode_d  = mode_q;
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = load_val;
      done_d  = 1'b0;
      mode_d  = mode;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN && tick && !pause) begin
      if (cnt_q > end_val) begin
        cnt_d = cnt_q - N'(1);
      end else begin
        // Expiry: status set overrides a coincident clear.
        exp_d = 1'b1;
        sts_d = 1'b1;
        if (mode_q == MODE_RELOAD) begin
          cnt_d = load_val;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign count      = cnt_q;
  assign running    = (state_q == ST_RUN);
  assign done       = done_q;
  assign expired    = exp_q;
  assign irq_status = sts_q;

endmodule

// File: rtl/multi_timer.sv
// CH-channel timer array sharing one prescaler (tick every presc_div+1 cycles);
// channel outputs are registered, irq is combinational from irq_status. No backpressure.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CH = DEF_CH,
  parameter int unsigned PW = DEF_PW
) (
  input logic          clk,
  input logic          rst,
  multi_timer_if.slave bus
);

  logic [PW-1:0] pcnt;
  logic          tick;

  // A divider lowered below the current phase just ticks on the next cycle.
  assign tick = (pcnt >= bus.presc_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    timer_channel #(.N(N)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start      (bus.start[k]),
      .stop       (bus.stop[k]),
      .pause      (bus.pause[k]),
      .mode       (bus.mode[k]),
      .irq_clr    (bus.irq_clr[k]),
      .load_val   (bus.load_val[k*N +: N]),
      .end_val    (bus.end_val[k*N +: N]),
      .count      (bus.count[k*N +: N]),
      .running    (bus.running[k]),
      .done       (bus.done[k]),
      .expired    (bus.expired[k]),
      .irq_status (bus.irq_status[k])
    );
  end

  assign bus.irq = |(bus.irq_status & bus.irq_en);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer; inputs change and outputs are sampled on the falling edge.
module tb_multi_timer;

  localparam int N  = 10;
  localparam int CH = 4;
  localparam int PW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multi_timer_if #(.N(N), .CH(CH), .PW(PW)) bus ();

  multi_timer #(.N(N), .CH(CH), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    checks++; if (bus.count !== '0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.count); end
    checks++; if (bus.running !== 4'b0) begin failures++; $display("FAIL reset_running got=%b exp=0000", bus.running); end
    checks++; if (bus.done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
    checks++; if (bus.expired !== 4'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0000", bus.expired); end
    checks++; if (bus.irq_status !== 4'b0 || bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq sts=%b irq=%b exp=0000/0", bus.irq_status, bus.irq); end
  endtask

  task automatic test_oneshot();
    bus.presc_div = '0;
    bus.load_val[0 +: N] = 10'd5;
    bus.end_val[0 +: N]  = 10'd2;
    bus.mode[0]  = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.count[0 +: N] !== 10'(5 - i) || bus.running[0] !== 1'b1 || bus.expired[0] !== 1'b0)
        begin failures++; $display("FAIL oneshot_count step=%0d got=%0d run=%b exp_pulse=%b want=%0d/1/0", i, bus.count[0 +: N], bus.running[0], bus.expired[0], 5 - i); end
      @(negedge clk);
    end
    checks++; if (bus.expired[0] !== 1'b1 || bus.done[0] !== 1'b1 || bus.running[0] !== 1'b0 || bus.count[0 +: N] !== 10'd2)
      begin failures++; $display("FAIL oneshot_expiry exp=%b done=%b run=%b cnt=%0d want=1/1/0/2", bus.expired[0], bus.done[0], bus.running[0], bus.count[0 +: N]); end
    checks++; if (bus.irq_status[0] !== 1'b1) begin failures++; $display("FAIL oneshot_status got=%b exp=1", bus.irq_status[0]); end
    @(negedge clk);
    checks++; if (bus.expired[0] !== 1'b0 || bus.count[0 +: N] !== 10'd2 || bus.done[0] !== 1'b1)
      begin failures++; $display("FAIL oneshot_after exp=%b cnt=%0d done=%b want=0/2/1", bus.expired[0], bus.count[0 +: N], bus.done[0]); end
    bus.irq_clr[0] = 1'b1;
    @(negedge clk);
    bus.irq_clr[0] = 1'b0;
    checks++; if (bus.irq_status[0] !== 1'b0) begin failures++; $display("FAIL oneshot_clr got=%b exp=0", bus.irq_status[0]); end
  endtask

  task automatic test_reload();
    int gap;
    bus.presc_div = 8'd3;
    bus.irq_en = 4'b0000;
    bus.load_val[1*N +: N] = 10'd3;
    bus.end_val[1*N +: N]  = 10'd0;
    bus.mode[1]  = 1'b1;
    bus.start[1] = 1'b1;
    @(negedge clk);
    bus.start[1] = 1'b0;
    gap = 0;
    while (bus.expired[1] !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
    checks++; if (bus.expired[1] !== 1'b1) begin failures++; $display("FAIL reload_first no expiry within %0d cycles", gap); end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (bus.expired[1] !== 1'b1 && gap < 40);
      checks++; if (gap !== 16) begin failures++; $display("FAIL reload_period got=%0d exp=16", gap); end
      checks++; if (bus.done[1] !== 1'b0 || bus.running[1] !== 1'b1) begin failures++; $display("FAIL reload_state done=%b run=%b exp=0/1", bus.done[1], bus.running[1]); end
      checks++; if (bus.irq_status[1] !== 1'b1) begin failures++; $display("FAIL reload_status got=%b exp=1", bus.irq_status[1]); end
    end
    #1;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reload_irq_masked got=%b exp=0", bus.irq); end
    bus.irq_en[1] = 1'b1;
    #1;
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL reload_irq_enabled got=%b exp=1", bus.irq); end
    bus.stop[1] = 1'b1;
    bus.irq_clr[1] = 1'b1;
    @(negedge clk);
    bus.stop[1] = 1'b0;
    bus.irq_clr[1] = 1'b0;
    bus.irq_en = 4'b0000;
    checks++; if (bus.running[1] !== 1'b0 || bus.irq_status[1] !== 1'b0) begin failures++; $display("FAIL reload_stop run=%b sts=%b exp=0/0", bus.running[1], bus.irq_status[1]); end
  endtask

  task automatic test_pause_stop();
    bus.presc_div = '0;
    bus.irq_en = 4'b1111;
    @(negedge clk);
    bus.load_val[2*N +: N] = 10'd10;
    bus.end_val[2*N +: N]  = 10'd0;
    bus.mode[2]  = 1'b0;
    bus.start[2] = 1'b1;
    @(negedge clk);
    bus.start[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.count[2*N +: N] !== 10'(10 - i)) begin failures++; $display("FAIL pause_pre step=%0d got=%0d exp=%0d", i, bus.count[2*N +: N], 10 - i); end
      @(negedge clk);
    end
    checks++; if (bus.count[2*N +: N] !== 10'd7) begin failures++; $display("FAIL pause_at7 got=%0d exp=7", bus.count[2*N +: N]); end
    bus.pause[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.count[2*N +: N] !== 10'd7 || bus.running[2] !== 1'b1) begin failures++; $display("FAIL pause_hold step=%0d cnt=%0d run=%b exp=7/1", i, bus.count[2*N +: N], bus.running[2]); end
    end
    bus.pause[2] = 1'b0;
    for (int v = 6; v >= 3; v--) begin
      @(negedge clk);
      checks++; if (bus.count[2*N +: N] !== 10'(v)) begin failures++; $display("FAIL pause_resume got=%0d exp=%0d", bus.count[2*N +: N], v); end
    end
    bus.stop[2] = 1'b1;
    @(negedge clk);
    bus.stop[2] = 1'b0;
    checks++; if (bus.running[2] !== 1'b0 || bus.count[2*N +: N] !== 10'd3 || bus.done[2] !== 1'b0)
      begin failures++; $display("FAIL stop_state run=%b cnt=%0d done=%b exp=0/3/0", bus.running[2], bus.count[2*N +: N], bus.done[2]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.expired[2] !== 1'b0 || bus.irq_status[2] !== 1'b0 || bus.irq !== 1'b0 || bus.count[2*N +: N] !== 10'd3)
        begin failures++; $display("FAIL stop_quiet exp=%b sts=%b irq=%b cnt=%0d exp=0/0/0/3", bus.expired[2], bus.irq_status[2], bus.irq, bus.count[2*N +: N]); end
      @(negedge clk);
    end
  endtask

  task automatic test_priority();
    bus.load_val[3*N +: N] = 10'd8;
    bus.end_val[3*N +: N]  = 10'd0;
    bus.mode[3]  = 1'b0;
    bus.start[3] = 1'b1;
    bus.stop[3]  = 1'b1;
    @(negedge clk);
    bus.start[3] = 1'b0;
    bus.stop[3]  = 1'b0;
    checks++; if (bus.running[3] !== 1'b1 || bus.count[3*N +: N] !== 10'd8) begin failures++; $display("FAIL prio_start_stop run=%b cnt=%0d exp=1/8", bus.running[3], bus.count[3*N +: N]); end
    bus.stop[3] = 1'b1;
    @(negedge clk);
    bus.stop[3] = 1'b0;
    checks++; if (bus.running[3] !== 1'b0) begin failures++; $display("FAIL prio_stop run=%b exp=0", bus.running[3]); end
    bus.load_val[3*N +: N] = 10'd2;
    bus.end_val[3*N +: N]  = 10'd5;
    bus.start[3] = 1'b1;
    @(negedge clk);
    bus.start[3] = 1'b0;
    checks++; if (bus.count[3*N +: N] !== 10'd2 || bus.running[3] !== 1'b1 || bus.expired[3] !== 1'b0)
      begin failures++; $display("FAIL edge_loaded cnt=%0d run=%b exp=%b want=2/1/0", bus.count[3*N +: N], bus.running[3], bus.expired[3]); end
    bus.irq_clr[3] = 1'b1;
    @(negedge clk);
    bus.irq_clr[3] = 1'b0;
    checks++; if (bus.expired[3] !== 1'b1 || bus.done[3] !== 1'b1 || bus.running[3] !== 1'b0)
      begin failures++; $display("FAIL edge_first_tick exp=%b done=%b run=%b want=1/1/0", bus.expired[3], bus.done[3], bus.running[3]); end
    checks++; if (bus.irq_status[3] !== 1'b1 || bus.irq !== 1'b1) begin failures++; $display("FAIL set_beats_clr sts=%b irq=%b exp=1/1", bus.irq_status[3], bus.irq); end
    bus.irq_clr[3] = 1'b1;
    @(negedge clk);
    bus.irq_clr[3] = 1'b0;
    checks++; if (bus.irq_status[3] !== 1'b0 || bus.irq !== 1'b0 || bus.done[3] !== 1'b1)
      begin failures++; $display("FAIL clr_alone sts=%b irq=%b done=%b exp=0/0/1", bus.irq_status[3], bus.irq, bus.done[3]); end
  endtask

  task automatic test_restart_reset();
    bus.load_val[0 +: N] = 10'd20;
    bus.end_val[0 +: N]  = 10'd0;
    bus.mode[0]  = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    checks++; if (bus.count[0 +: N] !== 10'd20 || bus.done[0] !== 1'b0) begin failures++; $display("FAIL restart_load cnt=%0d done=%b exp=20/0", bus.count[0 +: N], bus.done[0]); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.count[0 +: N] !== 10'd18) begin failures++; $display("FAIL restart_mid got=%0d exp=18", bus.count[0 +: N]); end
    bus.load_val[0 +: N] = 10'd15;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    checks++; if (bus.count[0 +: N] !== 10'd15 || bus.running[0] !== 1'b1) begin failures++; $display("FAIL restart_reload cnt=%0d run=%b exp=15/1", bus.count[0 +: N], bus.running[0]); end
    @(negedge clk);
    checks++; if (bus.count[0 +: N] !== 10'd14) begin failures++; $display("FAIL restart_count got=%0d exp=14", bus.count[0 +: N]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== '0 || bus.running !== 4'b0 || bus.done !== 4'b0 || bus.expired !== 4'b0 || bus.irq_status !== 4'b0 || bus.irq !== 1'b0)
      begin failures++; $display("FAIL async_reset cnt=%h run=%b done=%b exp=%b sts=%b irq=%b want all 0", bus.count, bus.running, bus.done, bus.expired, bus.irq_status, bus.irq); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== '0 || bus.running !== 4'b0) begin failures++; $display("FAIL post_reset cnt=%h run=%b exp=0/0000", bus.count, bus.running); end
  endtask

  task automatic test_independent();
    logic [3:0] want;
    bus.presc_div = '0;
    bus.load_val = {10'd3, 10'd9, 10'd4, 10'd6};
    bus.end_val  = {10'd3, 10'd3, 10'd0, 10'd1};
    bus.mode     = 4'b0010;
    bus.start    = 4'b1111;
    @(negedge clk);
    bus.start = 4'b0000;
    checks++; if (bus.count !== {10'd3, 10'd9, 10'd4, 10'd6}) begin failures++; $display("FAIL indep_load got=%h exp=%h", bus.count, {10'd3, 10'd9, 10'd4, 10'd6}); end
    for (int n = 1; n <= 17; n++) begin
      want = {n == 2, n == 8, (n == 6 || n == 11 || n == 16), n == 7};
      checks++; if (bus.expired !== want) begin failures++; $display("FAIL indep_expired cyc=%0d got=%b exp=%b", n, bus.expired, want); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 4'b1101 || bus.running !== 4'b0010) begin failures++; $display("FAIL indep_final done=%b run=%b exp=1101/0010", bus.done, bus.running); end
    checks++; if (bus.count[0 +: N] !== 10'd1 || bus.count[2*N +: N] !== 10'd3 || bus.count[3*N +: N] !== 10'd3)
      begin failures++; $display("FAIL indep_hold c0=%0d c2=%0d c3=%0d exp=1/3/3", bus.count[0 +: N], bus.count[2*N +: N], bus.count[3*N +: N]); end
    bus.stop[1] = 1'b1;
    @(negedge clk);
    bus.stop[1] = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.presc_div = '0;
    bus.start = '0;
    bus.stop = '0;
    bus.pause = '0;
    bus.mode = '0;
    bus.load_val = '0;
    bus.end_val = '0;
    bus.irq_en = '0;
    bus.irq_clr = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_reload();
    test_pause_stop();
    test_priority();
    test_restart_reset();
    test_independent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- CH-channel down-counting timer array sharing one programmable prescaler.
- Each channel counts from a loaded value down to a per-channel end value.
- Each channel runs one-shot or auto-reload (periodic), with pause, abort, and a sticky maskable interrupt.
- Sits beside the control FSMs as the common timebase/timeout resource.

Parameters:
N, 10, counter width per channel (bits)
CH, 4, number of independent channels
PW, 8, prescaler divider width (bits)

Ports:
clk  input  1  clock
rst  input  1  reset
presc_div  input  PW  prescaler divide value; tick every presc_div+1 clk cycles
start  input  CH  per-channel start/restart pulse
stop  input  CH  per-channel abort pulse
pause  input  CH  per-channel level; freezes count while high
mode  input  CH  per-channel 0=one-shot, 1=auto-reload; sampled at start
load_val  input  CH*N  per-channel load value, channel k at [k*N +: N]
end_val  input  CH*N  per-channel terminal value, same packing
irq_en  input  CH  per-channel interrupt mask
irq_clr  input  CH  per-channel sticky-status clear pulse
count  output  CH*N  current per-channel count
running  output  CH  channel in RUN state
done  output  CH  one-shot completion level
expired  output  CH  one-cycle pulse on every expiry
irq_status  output  CH  sticky expiry flags
irq  output  1  OR of (irq_status & irq_en)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: count, running, done, expired, irq_status, prescaler counter and latched modes all go to 0; irq=0.
- Prescaler:
  - pcnt counts 0..presc_div.
  - tick=1 in a cycle where pcnt >= presc_div; pcnt <= 0 that cycle, otherwise pcnt+1.
  - presc_div=0 gives tick every cycle.
  - presc_div changed below pcnt: tick next cycle, then normal period. No glitch beyond that.
- Channel states: IDLE, RUN. Pause is a RUN qualifier, not a state.
- Priority per channel, per cycle: start > stop > tick processing.
- start[k]:
  - count <= load_val[k]; state RUN; done[k] <= 0; mode latched.
  - Start in RUN restarts. Same-cycle tick is ignored.
- stop[k]:
  - state IDLE; count holds; done unchanged; no expiry, no irq.
- In RUN with tick=1 and pause[k]=0:
  - count > end_val: count <= count-1.
  - else expiry: expired[k]=1 for one cycle; irq_status[k] <= 1.
    - one-shot: state IDLE, done[k] <= 1, count holds.
    - auto-reload: count <= load_val[k] (current input value), stay RUN.
- pause[k]=1 in RUN: count and state frozen; ticks during pause are lost, not queued.
- Latency: with presc_div=0, load L > end E, start at cycle 0:
  - count=L at cycle 1; expiry pulse at cycle L-E+2.
  - Auto-reload period = (L-E+1) ticks.
- load_val <= end_val: expires on first tick after start.
- Unsigned compare, no wrap; count never goes below end_val, so no underflow.
- irq_status:
  - set on expiry, cleared by irq_clr.
  - Simultaneous set and clear: set wins.
- irq is combinational from registered irq_status and irq_en.
- Mode and end_val changes while running:
  - mode takes effect only at next start.
  - end_val is used live every tick.
- Reset mid-count: immediate return to reset values; no expired pulse.

Decomposition:
- Package timer_pkg:
  - channel state enum (ST_IDLE, ST_RUN)
  - mode constants MODE_ONESHOT=0, MODE_RELOAD=1
  - default widths
- Sub-module timer_channel (one channel, N-bit) instantiated CH times via generate.
- Prescaler and irq OR-reduction live in multi_timer top.

Test Plan:
1. Reset and one-shot: presc_div=0, ch0 L=5 E=2 one-shot, start pulse.
   - count 5,4,3,2; expired and done[0] rise 5 cycles after start.
   - running[0] falls same edge; count stays 2.
2. Auto-reload with prescaler: presc_div=3, ch1 L=3 E=0 reload.
   - expired[1] pulses every 16 clk; done[1] stays 0.
   - irq_status[1] sticky; irq=1 only with irq_en[1]=1.
3. Pause and stop: ch2 L=10 E=0, presc_div=0.
   - pause high 4 cycles at count 7: count holds 7, then resumes.
   - stop at count 3: running=0, count=3, no expired, no irq.
4. Priority and edge values:
   - start and stop same cycle: channel runs from load.
   - L=2 E=5: expires on first tick.
   - irq_clr coincident with expiry: irq_status stays 1.
5. Restart and async reset:
   - start re-pulsed mid-count: count reloads, done cleared.
   - rst asserted mid-count between clk edges: all outputs 0 immediately.
6. Channel independence: all CH channels run with different L/E/modes concurrently.
   - each expires at its own computed cycle; no cross-channel effect.
